// File: rtl/rgb_to_luma.sv
// ============================================================================
// Module      : rgb_to_luma
// Description : RGB888 to 8-bit luma converter with 3-clk matched sync
//               delay, frame-start gating and per-frame geometry checking.
//               Optional frame statistics ports: RGB_TO_LUMA_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_to_luma #(
    parameter int MAX_COLS = 1600,
    parameter int MAX_ROWS = 900
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    input  logic        dv_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [7:0]  y_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        err_o
`ifdef RGB_TO_LUMA_STATS_EN
    ,
    output logic [10:0] frame_cols_o,
    output logic [9:0]  frame_rows_o
`endif
);

    localparam logic [10:0] C_MAX_COLS = 11'(MAX_COLS);
    localparam logic [9:0]  C_MAX_ROWS = 10'(MAX_ROWS);

    typedef enum logic [0:0] {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t       state_q;

    logic         vs_dly_q;
    logic         hs_dly_q;
    logic         w_vs_rise;
    logic         w_hs_rise;
    logic         w_dv_ok;

    // ------------------------------------------------------------------
    // Edge detection and input-side dv gating
    // ------------------------------------------------------------------
    assign w_vs_rise = vs_i & ~vs_dly_q;
    assign w_hs_rise = hs_i & ~hs_dly_q;
    // A pixel sampled on the frame-start clock already belongs to the new frame.
    assign w_dv_ok   = dv_i & ((state_q == RUN) | w_vs_rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_dly_q <= 1'b0;
            hs_dly_q <= 1'b0;
        end else begin
            vs_dly_q <= vs_i;
            hs_dly_q <= hs_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC_WAIT;
        end else begin
            case (state_q)
                SYNC_WAIT: if (w_vs_rise) state_q <= RUN;
                RUN:       state_q <= RUN;
                default:   state_q <= SYNC_WAIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data pipeline: products -> rounded sum -> luma
    // ------------------------------------------------------------------
    logic [14:0] p_r_q;
    logic [15:0] p_g_q;
    logic [12:0] p_b_q;
    logic [16:0] sum_q;
    logic [7:0]  y_q;
    logic        dv1_q;
    logic        dv2_q;
    logic        dv3_q;
    logic [2:0]  hs_sr_q;
    logic [2:0]  vs_sr_q;

    logic [14:0] w_p_r;
    logic [15:0] w_p_g;
    logic [12:0] w_p_b;
    logic [16:0] w_sum;
    logic [7:0]  w_y;

    assign w_p_r = 15'(r_i) * 15'd77;
    assign w_p_g = 16'(g_i) * 16'd150;
    assign w_p_b = 13'(b_i) * 13'd29;
    assign w_sum = 17'(p_r_q) + 17'(p_g_q) + 17'(p_b_q) + 17'd128;
    // Sum peaks at 65408, so the top byte of the 16 LSBs never needs clipping.
    assign w_y   = 8'(sum_q >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_r_q   <= '0;
            p_g_q   <= '0;
            p_b_q   <= '0;
            sum_q   <= '0;
            y_q     <= '0;
            dv1_q   <= 1'b0;
            dv2_q   <= 1'b0;
            dv3_q   <= 1'b0;
            hs_sr_q <= '0;
            vs_sr_q <= '0;
        end else begin
            dv1_q   <= w_dv_ok;
            dv2_q   <= dv1_q;
            dv3_q   <= dv2_q;
            hs_sr_q <= {hs_sr_q[1:0], hs_i};
            vs_sr_q <= {vs_sr_q[1:0], vs_i};
            if (dv_i) begin
                p_r_q <= w_p_r;
                p_g_q <= w_p_g;
                p_b_q <= w_p_b;
            end
            if (dv1_q) begin
                sum_q <= w_sum;
            end
            if (dv2_q) begin
                y_q <= w_y;
            end
        end
    end

    assign y_o  = y_q;
    assign dv_o = dv3_q;
    assign hs_o = hs_sr_q[2];
    assign vs_o = vs_sr_q[2];

    // ------------------------------------------------------------------
    // Geometry counters and sticky error
    // ------------------------------------------------------------------
    logic [10:0] col_q;
    logic [10:0] col_d;
    logic [9:0]  row_q;
    logic [9:0]  row_d;
    logic        err_q;
    logic        err_d;
    logic        w_line_open;

    assign w_line_open = (col_q != 11'd0);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        err_d = err_q;
        if (w_vs_rise) begin
            col_d = '0;
            row_d = '0;
            err_d = 1'b0;
        end else if (state_q == RUN) begin
            if (w_hs_rise) begin
                col_d = dv_i ? 11'd1 : 11'd0;
                // Empty lines (blanking hs pulses) do not count as rows.
                if (w_line_open) begin
                    if (row_q == C_MAX_ROWS) begin
                        err_d = 1'b1;
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                end
            end else if (dv_i) begin
                if (col_q == C_MAX_COLS) begin
                    err_d = 1'b1;
                end else begin
                    col_d = col_q + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            err_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef RGB_TO_LUMA_STATS_EN
    // ------------------------------------------------------------------
    // Frame statistics latched at each frame start
    // ------------------------------------------------------------------
    logic [10:0] last_cols_q;
    logic [10:0] frame_cols_q;
    logic [9:0]  frame_rows_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cols_q  <= '0;
            frame_cols_q <= '0;
            frame_rows_q <= '0;
        end else if (w_vs_rise) begin
            last_cols_q <= '0;
            if (state_q == RUN) begin
                // An unterminated line at frame end still counts as a row.
                frame_cols_q <= w_line_open ? col_q : last_cols_q;
                frame_rows_q <= row_q + {9'd0, w_line_open};
            end
        end else if ((state_q == RUN) && w_hs_rise && w_line_open) begin
            last_cols_q <= col_q;
        end
    end

    assign frame_cols_o = frame_cols_q;
    assign frame_rows_o = frame_rows_q;
`endif

endmodule

`default_nettype wire
